// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard stall unit: register-address width,
// the hard-wired zero register and the stall FSM state encoding.
package hazard_stall_unit_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } hazState_e;

endpackage

// File: rtl/hazard_stall_unit_match.sv
// Producer/consumer register comparator: true when a producer destination feeds a
// source operand the IF/ID instruction actually reads; $0 never matches.
module hazard_match #(
   parameter int REG_ADDR_W = hazard_stall_unit_pkg::REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] dst,
   input  logic [REG_ADDR_W-1:0] srcRs,
   input  logic [REG_ADDR_W-1:0] srcRt,
   input  logic                  usesRs,
   input  logic                  usesRt,
   output logic                  hit
);
   import hazard_stall_unit_pkg::*;

   // Dependence check against both source operands
   always_comb begin
      hit = (dst != REG_ADDR_W'(ZERO_REG)) &&
            ((usesRs && (dst == srcRs)) || (usesRt && (dst == srcRt)));
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use and branch-in-ID hazard detector with a multi-cycle stall countdown
// and a saturating stalled-cycle counter.
module hazard_stall_unit #(
   parameter int REG_ADDR_W   = hazard_stall_unit_pkg::REG_ADDR_W,
   parameter int LOAD_LATENCY = 1,
   parameter int BRANCH_IN_ID = 0,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_ex_mem_read,
   input  logic                   id_ex_reg_write,
   input  logic [REG_ADDR_W-1:0]  id_ex_rt,
   input  logic                   ex_mem_mem_read,
   input  logic [REG_ADDR_W-1:0]  ex_mem_rt,
   input  logic [REG_ADDR_W-1:0]  if_id_rs,
   input  logic [REG_ADDR_W-1:0]  if_id_rt,
   input  logic                   if_id_uses_rs,
   input  logic                   if_id_uses_rt,
   input  logic                   if_id_branch,
   input  logic                   flush,
   output logic                   stall,
   output logic                   pc_write,
   output logic                   if_id_write,
   output logic                   id_ex_bubble,
   output logic [STALL_CNT_W-1:0] stall_cycles
);
   import hazard_stall_unit_pkg::*;

   localparam int         REM_W  = $clog2(LOAD_LATENCY + 2);
   localparam logic [3:0] LOAD_N = 4'(LOAD_LATENCY);
   localparam logic       BR_EN  = (BRANCH_IN_ID != 0);

   hazState_e             state_r;
   hazState_e             nextState_s;
   logic [REM_W-1:0]      remain_r;
   logic [REM_W-1:0]      nextRemain_s;
   logic                  idExHit_s;
   logic                  exMemHit_s;
   logic                  brActive_s;
   logic [3:0]            need_s;
   logic                  stall_s;
   logic [STALL_CNT_W-1:0] stallCycles_r;

   hazard_match #(.REG_ADDR_W(REG_ADDR_W)) uIdExMatch (
      .dst    (id_ex_rt),
      .srcRs  (if_id_rs),
      .srcRt  (if_id_rt),
      .usesRs (if_id_uses_rs),
      .usesRt (if_id_uses_rt),
      .hit    (idExHit_s)
   );

   hazard_match #(.REG_ADDR_W(REG_ADDR_W)) uExMemMatch (
      .dst    (ex_mem_rt),
      .srcRs  (if_id_rs),
      .srcRt  (if_id_rt),
      .usesRs (if_id_uses_rs),
      .usesRt (if_id_uses_rt),
      .hit    (exMemHit_s)
   );

   // Bubble demand; a load-use count takes precedence over any branch-only count
   always_comb begin
      brActive_s = BR_EN & if_id_branch;
      need_s     = 4'd0;
      if (id_ex_mem_read && idExHit_s) begin
         need_s = LOAD_N + {3'b000, brActive_s};
      end else if (brActive_s &&
                   ((id_ex_reg_write && !id_ex_mem_read && idExHit_s) ||
                    (ex_mem_mem_read && exMemHit_s))) begin
         need_s = 4'd1;
      end else begin
         need_s = 4'd0;
      end
   end

   // Stall FSM next state; reset and flush override everything
   always_comb begin
      nextState_s  = state_r;
      nextRemain_s = remain_r;
      stall_s      = 1'b0;
      if (!rst_n || flush) begin
         nextState_s  = IDLE;
         nextRemain_s = {REM_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (need_s != 4'd0) begin
                  stall_s      = 1'b1;
                  nextRemain_s = REM_W'(need_s - 4'd1);
                  nextState_s  = (need_s > 4'd1) ? HOLD : IDLE;
               end else begin
                  nextRemain_s = {REM_W{1'b0}};
               end
            end
            HOLD: begin
               stall_s      = 1'b1;
               nextRemain_s = remain_r - REM_W'(1);
               if (remain_r == REM_W'(1)) begin
                  nextState_s = IDLE;
               end else begin
                  nextState_s = HOLD;
               end
            end
            default: begin
               nextState_s  = IDLE;
               nextRemain_s = {REM_W{1'b0}};
            end
         endcase
      end
   end

   // FSM state and countdown registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         remain_r <= {REM_W{1'b0}};
      end else begin
         state_r  <= nextState_s;
         remain_r <= nextRemain_s;
      end
   end

   // Saturating count of stalled cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCycles_r <= {STALL_CNT_W{1'b0}};
      end else if (stall_s && (stallCycles_r != {STALL_CNT_W{1'b1}})) begin
         stallCycles_r <= stallCycles_r + STALL_CNT_W'(1);
      end else begin
         stallCycles_r <= stallCycles_r;
      end
   end

   assign stall        = stall_s;
   assign pc_write     = ~stall_s;
   assign if_id_write  = ~stall_s;
   assign id_ex_bubble = stall_s;
   assign stall_cycles = stallCycles_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Three configurations of hazard_stall_unit driven in parallel and checked against
// an integer countdown model built from the hazard rules.
module tb_hazard_stall_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
   logic       uses_rs, uses_rt, branch, flush;
   logic [4:0] id_ex_rt, ex_mem_rt, rs, rt;
   logic       st[3], pw[3], iw[3], bb[3];
   logic [15:0] c0, c2;
   logic [3:0]  c1;

   int total = 0;
   int bad   = 0;
   int pend[3] = '{0, 0, 0};
   int cnt[3]  = '{0, 0, 0};

   // u0: LL=1 no branch; u1: LL=3 4-bit counter; u2: LL=1 branch in ID
   hazard_stall_unit #(.LOAD_LATENCY(1), .BRANCH_IN_ID(0), .STALL_CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
      .id_ex_rt(id_ex_rt), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rt(ex_mem_rt),
      .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rs(uses_rs), .if_id_uses_rt(uses_rt),
      .if_id_branch(branch), .flush(flush), .stall(st[0]), .pc_write(pw[0]),
      .if_id_write(iw[0]), .id_ex_bubble(bb[0]), .stall_cycles(c0));

   hazard_stall_unit #(.LOAD_LATENCY(3), .BRANCH_IN_ID(0), .STALL_CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
      .id_ex_rt(id_ex_rt), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rt(ex_mem_rt),
      .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rs(uses_rs), .if_id_uses_rt(uses_rt),
      .if_id_branch(branch), .flush(flush), .stall(st[1]), .pc_write(pw[1]),
      .if_id_write(iw[1]), .id_ex_bubble(bb[1]), .stall_cycles(c1));

   hazard_stall_unit #(.LOAD_LATENCY(1), .BRANCH_IN_ID(1), .STALL_CNT_W(16)) u2 (
      .clk(clk), .rst_n(rst_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
      .id_ex_rt(id_ex_rt), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rt(ex_mem_rt),
      .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rs(uses_rs), .if_id_uses_rt(uses_rt),
      .if_id_branch(branch), .flush(flush), .stall(st[2]), .pc_write(pw[2]),
      .if_id_write(iw[2]), .id_ex_bubble(bb[2]), .stall_cycles(c2));

   function automatic int ll(int i);
      return (i == 1) ? 3 : 1;
   endfunction

   function automatic int cmax(int i);
      return (i == 1) ? 15 : 65535;
   endfunction

   function automatic logic [15:0] dutCnt(int i);
      if (i == 0) return c0;
      if (i == 1) return {12'd0, c1};
      return c2;
   endfunction

   function automatic bit hits(logic [4:0] d);
      return (d != 5'd0) && ((uses_rs && d == rs) || (uses_rt && d == rt));
   endfunction

   function automatic int need(int i);
      bit mI = hits(id_ex_rt);
      bit mE = hits(ex_mem_rt);
      bit b  = (i == 2) && branch;
      if (id_ex_mem_read && mI) return ll(i) + (b ? 1 : 0);
      if (b && ((id_ex_reg_write && !id_ex_mem_read && mI) || (ex_mem_mem_read && mE))) return 1;
      return 0;
   endfunction

   function automatic bit expStall(int i);
      if (!rst_n || flush) return 1'b0;
      if (pend[i] > 0) return 1'b1;
      return need(i) > 0;
   endfunction

   task automatic advance();
      int np[3];
      int nc[3];
      for (int i = 0; i < 3; i++) begin
         np[i] = pend[i];
         nc[i] = cnt[i];
         if (!rst_n) begin
            np[i] = 0;
            nc[i] = 0;
         end else begin
            if (expStall(i) && cnt[i] < cmax(i)) nc[i] = cnt[i] + 1;
            if (flush) np[i] = 0;
            else if (pend[i] > 0) np[i] = pend[i] - 1;
            else np[i] = (need(i) > 0) ? need(i) - 1 : 0;
         end
      end
      @(posedge clk);
      pend = np;
      cnt  = nc;
      #1;
   endtask

   task automatic setIdle();
      rst_n = 1'b1; flush = 1'b0; branch = 1'b0;
      id_ex_mem_read = 1'b0; id_ex_reg_write = 1'b0; id_ex_rt = 5'd0;
      ex_mem_mem_read = 1'b0; ex_mem_rt = 5'd0;
      rs = 5'd0; rt = 5'd0; uses_rs = 1'b0; uses_rt = 1'b0;
   endtask

   task automatic setLoad(logic [4:0] dst, logic [4:0] srs, logic [4:0] srt, logic urs, logic urt);
      id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_rt = dst;
      rs = srs; rt = srt; uses_rs = urs; uses_rt = urt;
   endtask

   task automatic test_reset();
      setIdle();
      rst_n = 1'b0;
      setLoad(5'd2, 5'd2, 5'd4, 1'b1, 1'b1);
      advance();
      advance();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({st[i], pw[i], iw[i], bb[i]} !== 4'b0110) begin
            bad++;
            $display("FAIL reset_outs u%0d: got %b want 0110", i, {st[i], pw[i], iw[i], bb[i]});
         end
         total++;
         if (dutCnt(i) !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt u%0d: got %0d want 0", i, dutCnt(i));
         end
      end
      advance();
   endtask

   task automatic test_load_use();
      int seen[3];
      int want[2][3] = '{'{1, 3, 1}, '{1, 3, 1}};
      for (int sc = 0; sc < 2; sc++) begin
         seen = '{0, 0, 0};
         for (int k = 0; k < 5; k++) begin
            setIdle();
            if (k == 0) begin
               if (sc == 0) setLoad(5'd2, 5'd2, 5'd4, 1'b1, 1'b1);
               else setLoad(5'd5, 5'd6, 5'd5, 1'b1, 1'b1);
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               total++;
               if ({st[i], pw[i], iw[i], bb[i]} !== {expStall(i), !expStall(i), !expStall(i), expStall(i)}) begin
                  bad++;
                  $display("FAIL load_use u%0d sc%0d k%0d: got %b want stall=%b", i, sc, k,
                           {st[i], pw[i], iw[i], bb[i]}, expStall(i));
               end
               if (st[i] === 1'b1) seen[i]++;
            end
            advance();
         end
         for (int i = 0; i < 3; i++) begin
            total++;
            if (seen[i] != want[sc][i]) begin
               bad++;
               $display("FAIL load_use_len u%0d sc%0d: got %0d want %0d", i, sc, seen[i], want[sc][i]);
            end
            total++;
            if (dutCnt(i) !== 16'(cnt[i])) begin
               bad++;
               $display("FAIL load_use_cnt u%0d: got %0d want %0d", i, dutCnt(i), cnt[i]);
            end
         end
      end
   endtask

   task automatic test_zero_reg();
      for (int k = 0; k < 3; k++) begin
         setIdle();
         if (k == 0) setLoad(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
         if (k == 1) setLoad(5'd7, 5'd1, 5'd7, 1'b1, 1'b0);
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            total++;
            if (st[i] !== 1'b0 || pw[i] !== 1'b1) begin
               bad++;
               $display("FAIL zero_reg u%0d k%0d: stall=%b pc_write=%b want 0/1", i, k, st[i], pw[i]);
            end
         end
         advance();
      end
   endtask

   task automatic test_branch();
      int seen[3];
      int want[4][3] = '{'{0, 0, 1}, '{1, 3, 2}, '{0, 0, 1}, '{1, 3, 2}};
      for (int sc = 0; sc < 4; sc++) begin
         seen = '{0, 0, 0};
         for (int k = 0; k < 5; k++) begin
            setIdle();
            if (k == 0) begin
               branch = 1'b1; rs = 5'd8; rt = 5'd9; uses_rs = 1'b1; uses_rt = 1'b1;
               case (sc)
                  0: begin id_ex_reg_write = 1'b1; id_ex_rt = 5'd8; end
                  1: setLoad(5'd8, 5'd8, 5'd9, 1'b1, 1'b1);
                  2: begin ex_mem_mem_read = 1'b1; ex_mem_rt = 5'd9; end
                  default: begin
                     setLoad(5'd8, 5'd8, 5'd9, 1'b1, 1'b1);
                     ex_mem_mem_read = 1'b1; ex_mem_rt = 5'd9;
                  end
               endcase
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               total++;
               if (st[i] !== expStall(i)) begin
                  bad++;
                  $display("FAIL branch u%0d sc%0d k%0d: stall=%b want %b", i, sc, k, st[i], expStall(i));
               end
               if (st[i] === 1'b1) seen[i]++;
            end
            advance();
         end
         for (int i = 0; i < 3; i++) begin
            total++;
            if (seen[i] != want[sc][i]) begin
               bad++;
               $display("FAIL branch_len u%0d sc%0d: got %0d want %0d", i, sc, seen[i], want[sc][i]);
            end
         end
      end
   endtask

   task automatic test_flush_reset();
      for (int k = 0; k < 4; k++) begin
         setIdle();
         if (k == 0) setLoad(5'd5, 5'd6, 5'd5, 1'b1, 1'b1);
         if (k == 1) flush = 1'b1;
         @(negedge clk);
         total++;
         if (st[1] !== expStall(1) || (k >= 1 && st[1] !== 1'b0)) begin
            bad++;
            $display("FAIL flush u1 k%0d: stall=%b want %b", k, st[1], (k == 0));
         end
         advance();
      end
      for (int k = 0; k < 5; k++) begin
         setIdle();
         if (k == 0) setLoad(5'd5, 5'd6, 5'd5, 1'b1, 1'b1);
         if (k == 2) rst_n = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            total++;
            if (st[i] !== expStall(i) || (k >= 2 && st[i] !== 1'b0)) begin
               bad++;
               $display("FAIL reset_hold u%0d k%0d: stall=%b want %b", i, k, st[i], expStall(i));
            end
            if (k >= 3) begin
               total++;
               if (dutCnt(i) !== 16'd0) begin
                  bad++;
                  $display("FAIL reset_hold_cnt u%0d k%0d: got %0d want 0", i, k, dutCnt(i));
               end
            end
         end
         advance();
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 26; k++) begin
         setIdle();
         if (k < 22) setLoad(5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            total++;
            if (st[i] !== expStall(i)) begin
               bad++;
               $display("FAIL saturate u%0d k%0d: stall=%b want %b", i, k, st[i], expStall(i));
            end
         end
         advance();
      end
      @(negedge clk);
      total++;
      if (c1 !== 4'd15) begin
         bad++;
         $display("FAIL saturate_cnt u1: got %0d want 15", c1);
      end
      total++;
      if (c0 !== 16'd22) begin
         bad++;
         $display("FAIL saturate_cnt u0: got %0d want 22", c0);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         rst_n           = ($urandom_range(39) != 0);
         flush           = ($urandom_range(9) == 0);
         branch          = $urandom_range(1);
         id_ex_mem_read  = $urandom_range(1);
         id_ex_reg_write = $urandom_range(1);
         ex_mem_mem_read = $urandom_range(1);
         uses_rs         = $urandom_range(1);
         uses_rt         = $urandom_range(1);
         id_ex_rt        = 5'($urandom_range(3));
         ex_mem_rt       = 5'($urandom_range(3));
         rs              = 5'($urandom_range(3));
         rt              = 5'($urandom_range(3));
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            total++;
            if ({st[i], pw[i], iw[i], bb[i]} !== {expStall(i), !expStall(i), !expStall(i), expStall(i)}) begin
               bad++;
               $display("FAIL random_outs u%0d k%0d: got %b want stall=%b", i, k,
                        {st[i], pw[i], iw[i], bb[i]}, expStall(i));
            end
            total++;
            if (dutCnt(i) !== 16'(cnt[i])) begin
               bad++;
               $display("FAIL random_cnt u%0d k%0d: got %0d want %0d", i, k, dutCnt(i), cnt[i]);
            end
         end
         advance();
      end
   endtask

   initial begin
      setIdle();
      rst_n = 1'b0;
      test_reset();
      test_load_use();
      test_zero_reg();
      test_branch();
      test_flush_reset();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
